control_sequencer: RTL and testbench



---
 rtl/cu_pkg.sv | 88 ++++++++
 rtl/cu_ctrl_decode.sv | 112 +++++++++++
 rtl/control_sequencer.sv | 137 +++++++++++++
 tb/tb_control_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the control sequencer: opcodes, phases, datapath
// select/function codes, the packed control word and small decode helpers.
package cu_pkg;

  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_INC = 4'h3;
  localparam logic [3:0] OP_DEC = 4'h4;
  localparam logic [3:0] OP_BRA = 4'h5;
  localparam logic [3:0] OP_BNE = 4'h6;
  localparam logic [3:0] OP_HLT = 4'h7;

  typedef enum logic [1:0] {
    PH_RST   = 2'd0,
    PH_FETCH = 2'd1,
    PH_EXEC  = 2'd2,
    PH_HALT  = 2'd3
  } phase_t;

  localparam logic [1:0] RF_FN_LOAD  = 2'b01;
  localparam logic [1:0] RF_FN_DEC   = 2'b10;
  localparam logic [1:0] RF_FN_INC   = 2'b11;
  localparam logic [1:0] ARF_FN_LOAD = 2'b01;
  localparam logic [1:0] ARF_FN_INC  = 2'b10;
  localparam logic [1:0] IR_FN_LOAD  = 2'b01;

  localparam logic [3:0] ARF_SEL_PC = 4'b1000;
  localparam logic [3:0] ARF_SEL_AR = 4'b0100;
  localparam logic [3:0] SEL_ALL    = 4'b1111;

  localparam logic [1:0] ARF_OUT_AR = 2'b00;
  localparam logic [1:0] ARF_OUT_PC = 2'b11;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b01;
  localparam logic [1:0] MUX_IR  = 2'b10;
  localparam logic [1:0] MUX_ARF = 2'b11;

  localparam logic [3:0] ALU_FN_B = 4'b0001;

  typedef struct packed {
    logic [2:0] rf_o1_sel;
    logic [2:0] rf_o2_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_r_sel;
    logic [3:0] rf_t_sel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_out_a_sel;
    logic [1:0] arf_out_b_sel;
    logic [1:0] arf_fun_sel;
    logic [3:0] arf_r_sel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_fun_sel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } cw_t;

  // Memory chip select is active-low, so the idle word is not all zeros.
  function automatic cw_t idle_cw();
    cw_t c;
    c        = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  function automatic logic [3:0] rf_onehot(input logic [1:0] r);
    return 4'b1000 >> r;
  endfunction

  // Execute slots per opcode; zero means fetch follows decode directly.
  function automatic logic [2:0] exec_slots(input logic [3:0] op, input logic z);
    case (op)
      OP_LDI:         return 3'd2;
      OP_LD:          return 3'd5;
      OP_ST:          return 3'd4;
      OP_INC, OP_DEC: return 3'd3;
      OP_BRA:         return 3'd2;
      OP_BNE:         return z ? 3'd0 : 3'd2;
      default:        return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/cu_ctrl_decode.sv
// Moore control-word decode: maps (phase, sc, opcode, reg, z) to the datapath
// control word and flags the last slot of the current phase.
module cu_ctrl_decode
  import cu_pkg::*;
(
  input  phase_t     phase,
  input  logic [2:0] sc,
  input  logic [3:0] opcode,
  input  logic [1:0] reg_sel,
  input  logic       z,
  output cw_t        cw,
  output logic       last
);

  logic [3:0] onehot;
  logic [2:0] o2_sel;
  logic [2:0] n_exec;

  assign onehot = rf_onehot(reg_sel);
  assign o2_sel = {1'b1, reg_sel};
  assign n_exec = exec_slots(opcode, z);

  always_comb begin
    // NOTE: every output gets its idle default first, so no branch can infer a latch.
    cw   = idle_cw();
    last = 1'b0;
    unique case (phase)
      PH_RST: begin
        cw.rf_r_sel  = SEL_ALL;
        cw.rf_t_sel  = SEL_ALL;
        cw.arf_r_sel = SEL_ALL;
        cw.ir_enable = 1'b1;
        last         = 1'b1;
      end
      PH_FETCH: begin
        last = (sc == 3'd4);
        if (sc != 3'd4) cw.arf_out_b_sel = ARF_OUT_PC;
        if (sc == 3'd1 || sc == 3'd3) begin
          cw.mem_cs      = 1'b0;
          cw.ir_enable   = 1'b1;
          cw.ir_fun_sel  = IR_FN_LOAD;
          cw.ir_lh       = sc[1];
          cw.arf_r_sel   = ARF_SEL_PC;
          cw.arf_fun_sel = ARF_FN_INC;
        end
      end
      PH_EXEC: begin
        last = (sc == n_exec - 3'd1);
        case (opcode)
          OP_LDI: begin
            // Mux A is held into E1 so the registered mux output stays valid for the load.
            cw.mux_a_sel = MUX_IR;
            if (sc == 3'd1) begin
              cw.rf_fun_sel = RF_FN_LOAD;
              cw.rf_r_sel   = onehot;
            end
          end
          OP_LD: begin
            if (sc <= 3'd1) cw.mux_b_sel = MUX_IR;
            if (sc >= 3'd1) cw.arf_out_b_sel = ARF_OUT_AR;
            if (sc == 3'd1) begin
              cw.arf_r_sel   = ARF_SEL_AR;
              cw.arf_fun_sel = ARF_FN_LOAD;
            end
            if (sc >= 3'd3) begin
              cw.mem_cs    = 1'b0;
              cw.mux_a_sel = MUX_MEM;
            end
            if (sc == 3'd4) begin
              cw.rf_fun_sel = RF_FN_LOAD;
              cw.rf_r_sel   = onehot;
            end
          end
          OP_ST: begin
            cw.rf_o2_sel = o2_sel;
            if (sc == 3'd0) cw.mux_b_sel = MUX_IR;
            if (sc == 3'd1) begin
              cw.arf_r_sel   = ARF_SEL_AR;
              cw.arf_fun_sel = ARF_FN_LOAD;
            end
            if (sc >= 3'd1) cw.alu_fun_sel = ALU_FN_B;
            if (sc >= 3'd2) cw.arf_out_b_sel = ARF_OUT_AR;
            if (sc == 3'd3) begin
              cw.mem_cs = 1'b0;
              cw.mem_wr = 1'b1;
            end
          end
          OP_INC, OP_DEC: begin
            if (sc == 3'd0) begin
              cw.rf_fun_sel = (opcode == OP_INC) ? RF_FN_INC : RF_FN_DEC;
              cw.rf_r_sel   = onehot;
            end else begin
              cw.rf_o2_sel = o2_sel;
            end
            if (sc == 3'd2) cw.alu_fun_sel = ALU_FN_B;
          end
          OP_BRA, OP_BNE: begin
            // A not-taken BNE never reaches EXEC, so both share the branch slots.
            cw.mux_b_sel = MUX_IR;
            if (sc == 3'd1) begin
              cw.arf_r_sel   = ARF_SEL_PC;
              cw.arf_fun_sel = ARF_FN_LOAD;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the ALUSystem datapath: phase/sc/latch registers
// plus the control-word decode. Define CU_STEP_EN for the single-step port.
module control_sequencer
  import cu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
`ifdef CU_STEP_EN
  input  logic        step,
`endif
  input  logic [15:0] ir,
  input  logic [3:0]  alu_flags,
  output logic [2:0]  RF_O1Sel,
  output logic [2:0]  RF_O2Sel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutASel,
  output logic [1:0]  ARF_OutBSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        halted,
  output logic [2:0]  sc
);

  phase_t     phase_q;
  logic [2:0] sc_q;
  logic [3:0] opcode_q;
  logic [1:0] reg_q;
  logic [7:0] imm_q;
  logic       z_q;
  logic       step_go;
  logic       hold;
  logic       last;
  cw_t        cw;

`ifdef CU_STEP_EN
  assign step_go = step;
`else
  assign step_go = 1'b1;
`endif

  assign hold = (phase_q == PH_FETCH) && (sc_q == 3'd0) && !step_go;

  cu_ctrl_decode u_decode (
    .phase   (phase_q),
    .sc      (sc_q),
    .opcode  (opcode_q),
    .reg_sel (reg_q),
    .z       (z_q),
    .cw      (cw),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (!rst_n) begin
      phase_q  <= PH_RST;
      sc_q     <= '0;
      opcode_q <= '0;
      reg_q    <= '0;
      imm_q    <= '0;
      z_q      <= 1'b0;
    end else begin
      unique case (phase_q)
        PH_RST: begin
          phase_q <= PH_FETCH;
          sc_q    <= '0;
        end
        PH_FETCH: begin
          if (!hold) begin
            if (last) begin
              opcode_q <= ir[15:12];
              reg_q    <= ir[11:10];
              imm_q    <= ir[7:0];
              z_q      <= alu_flags[0];
              sc_q     <= '0;
              // Decode looks at the live IR, since the latches only update at this edge.
              if (ir[15:12] == OP_HLT)
                phase_q <= PH_HALT;
              else if (exec_slots(ir[15:12], alu_flags[0]) == 3'd0)
                phase_q <= PH_FETCH;
              else
                phase_q <= PH_EXEC;
            end else begin
              sc_q <= sc_q + 3'd1;
            end
          end
        end
        PH_EXEC: begin
          if (last) begin
            phase_q <= PH_FETCH;
            sc_q    <= '0;
          end else begin
            sc_q <= sc_q + 3'd1;
          end
        end
        PH_HALT: ;
      endcase
    end
  end

  // Address byte is carried for the datapath's benefit; the sequencer never reads it.
  logic unused_bits;
  assign unused_bits = ^{ir[9:8], alu_flags[3:1], imm_q};

  assign RF_O1Sel    = cw.rf_o1_sel;
  assign RF_O2Sel    = cw.rf_o2_sel;
  assign RF_FunSel   = cw.rf_fun_sel;
  assign RF_RSel     = cw.rf_r_sel;
  assign RF_TSel     = cw.rf_t_sel;
  assign ALU_FunSel  = cw.alu_fun_sel;
  assign ARF_OutASel = cw.arf_out_a_sel;
  assign ARF_OutBSel = cw.arf_out_b_sel;
  assign ARF_FunSel  = cw.arf_fun_sel;
  assign ARF_RSel    = cw.arf_r_sel;
  assign IR_LH       = cw.ir_lh;
  assign IR_Enable   = cw.ir_enable;
  assign IR_Funsel   = cw.ir_fun_sel;
  assign Mem_WR      = cw.mem_wr;
  assign Mem_CS      = cw.mem_cs;
  assign MuxASel     = cw.mux_a_sel;
  assign MuxBSel     = cw.mux_b_sel;
  assign MuxCSel     = cw.mux_c_sel;
  assign halted      = (phase_q == PH_HALT);
  assign sc          = sc_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: an instruction-level model queues
// the expected output word of every cycle; a negedge process compares them.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ir = '0;
  logic [3:0]  alu_flags = '0;
`ifdef CU_STEP_EN
  logic        step = 1'b1;
`endif

  logic [2:0] RF_O1Sel, RF_O2Sel, sc;
  logic [1:0] RF_FunSel, ARF_OutASel, ARF_OutBSel, ARF_FunSel, IR_Funsel, MuxASel, MuxBSel;
  logic [3:0] RF_RSel, RF_TSel, ALU_FunSel, ARF_RSel;
  logic       IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, halted;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef CU_STEP_EN
    .step        (step),
`endif
    .ir          (ir),
    .alu_flags   (alu_flags),
    .RF_O1Sel    (RF_O1Sel),
    .RF_O2Sel    (RF_O2Sel),
    .RF_FunSel   (RF_FunSel),
    .RF_RSel     (RF_RSel),
    .RF_TSel     (RF_TSel),
    .ALU_FunSel  (ALU_FunSel),
    .ARF_OutASel (ARF_OutASel),
    .ARF_OutBSel (ARF_OutBSel),
    .ARF_FunSel  (ARF_FunSel),
    .ARF_RSel    (ARF_RSel),
    .IR_LH       (IR_LH),
    .IR_Enable   (IR_Enable),
    .IR_Funsel   (IR_Funsel),
    .Mem_WR      (Mem_WR),
    .Mem_CS      (Mem_CS),
    .MuxASel     (MuxASel),
    .MuxBSel     (MuxBSel),
    .MuxCSel     (MuxCSel),
    .halted      (halted),
    .sc          (sc)
  );

  typedef struct packed {
    logic [2:0] o1;
    logic [2:0] o2;
    logic [1:0] rf_fun;
    logic [3:0] rf_r;
    logic [3:0] rf_t;
    logic [3:0] alu;
    logic [1:0] outa;
    logic [1:0] outb;
    logic [1:0] arf_fun;
    logic [3:0] arf_r;
    logic       lh;
    logic       ir_en;
    logic [1:0] ir_fun;
    logic       wr;
    logic       cs;
    logic [1:0] ma;
    logic [1:0] mb;
    logic       mc;
    logic       halted;
    logic [2:0] sc;
  } vec_t;

  vec_t act;
  assign act = {RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel, ARF_OutASel,
                ARF_OutBSel, ARF_FunSel, ARF_RSel, IR_LH, IR_Enable, IR_Funsel, Mem_WR,
                Mem_CS, MuxASel, MuxBSel, MuxCSel, halted, sc};

  int   vectors = 0;
  int   miscompares = 0;
  vec_t exp_q[$];
  vec_t act_log[$];
  vec_t cur_exp;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur_exp = exp_q.pop_front();
      act_log.push_back(act);
      check($sformatf("ir=%04h slot %0d word", ir, act_log.size() - 1), 64'(act), 64'(cur_exp));
    end
  end

  // ---- instruction-level model ----
  function automatic vec_t idle(input int s);
    vec_t v = '0;
    v.cs = 1'b1;
    v.sc = 3'(s);
    return v;
  endfunction

  function automatic vec_t fetch_word(input int s);
    vec_t v = idle(s);
    if (s != 4) v.outb = 2'b11;
    if (s == 1 || s == 3) begin
      v.cs = 1'b0; v.ir_en = 1'b1; v.ir_fun = 2'b01; v.lh = (s == 3);
      v.arf_r = 4'b1000; v.arf_fun = 2'b10;
    end
    return v;
  endfunction

  function automatic vec_t rst_word();
    vec_t v = idle(0);
    v.rf_r = 4'hF; v.rf_t = 4'hF; v.arf_r = 4'hF; v.ir_en = 1'b1;
    return v;
  endfunction

  function automatic vec_t halt_word();
    vec_t v = idle(0);
    v.halted = 1'b1;
    return v;
  endfunction

  task automatic push_instr(input logic [15:0] irv, input logic z, input int limit);
    vec_t       s[$];
    vec_t       v;
    logic [3:0] oh;
    logic [2:0] o2;
    oh = 4'b1000 >> irv[11:10];
    o2 = {1'b1, irv[11:10]};
    for (int i = 0; i < 5; i++) s.push_back(fetch_word(i));
    case (irv[15:12])
      4'h0: begin
        v = idle(0); v.ma = 2'b10; s.push_back(v);
        v = idle(1); v.ma = 2'b10; v.rf_fun = 2'b01; v.rf_r = oh; s.push_back(v);
      end
      4'h1: begin
        v = idle(0); v.mb = 2'b10; s.push_back(v);
        v = idle(1); v.mb = 2'b10; v.arf_r = 4'b0100; v.arf_fun = 2'b01; s.push_back(v);
        s.push_back(idle(2));
        v = idle(3); v.cs = 1'b0; v.ma = 2'b01; s.push_back(v);
        v = idle(4); v.cs = 1'b0; v.ma = 2'b01; v.rf_fun = 2'b01; v.rf_r = oh; s.push_back(v);
      end
      4'h2: begin
        v = idle(0); v.mb = 2'b10; v.o2 = o2; s.push_back(v);
        v = idle(1); v.o2 = o2; v.alu = 4'b0001; v.arf_r = 4'b0100; v.arf_fun = 2'b01; s.push_back(v);
        v = idle(2); v.o2 = o2; v.alu = 4'b0001; s.push_back(v);
        v = idle(3); v.o2 = o2; v.alu = 4'b0001; v.cs = 1'b0; v.wr = 1'b1; s.push_back(v);
      end
      4'h3, 4'h4: begin
        v = idle(0); v.rf_fun = (irv[15:12] == 4'h3) ? 2'b11 : 2'b10; v.rf_r = oh; s.push_back(v);
        v = idle(1); v.o2 = o2; s.push_back(v);
        v = idle(2); v.o2 = o2; v.alu = 4'b0001; s.push_back(v);
      end
      4'h5, 4'h6: begin
        if (irv[15:12] == 4'h5 || !z) begin
          v = idle(0); v.mb = 2'b10; s.push_back(v);
          v = idle(1); v.mb = 2'b10; v.arf_r = 4'b1000; v.arf_fun = 2'b01; s.push_back(v);
        end
      end
      4'h7: repeat (20) s.push_back(halt_word());
      default: ;
    endcase
    for (int i = 0; i < s.size() && i < limit; i++) exp_q.push_back(s[i]);
  endtask

  // Returns on the rising edge that begins the first unqueued cycle.
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0) begin
      if (n == 200) begin
        check("drain timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
      end else begin
        @(posedge clk);
        n++;
      end
    end
  endtask

  task automatic start(input logic [15:0] irv, input logic z, input int limit);
    drain();
    #1;
    ir = irv;
    alu_flags = {3'b101, z};
    act_log.delete();
    push_instr(irv, z, limit);
  endtask

  task automatic pulse_reset(input vec_t cur);
    drain();
    #1;
    rst_n = 1'b0;
    exp_q.push_back(cur);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(rst_word());
  endtask

  int cnt;

  initial begin
    #300000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(rst_word());
    drain();
    check("rst rf/arf enables", {act_log[0].rf_r, act_log[0].rf_t, act_log[0].arf_r}, 12'hFFF);
    check("rst halted/sc/cs", {act_log[0].halted, act_log[0].sc, act_log[0].cs}, 5'b00001);

    start(16'h042A, 1'b0, 99); drain();
    check("ldi E1 fun/rsel/muxa", {act_log[6].rf_fun, act_log[6].rf_r, act_log[6].ma}, {2'b01, 4'b0100, 2'b10});
    check("ldi length", 64'(act_log.size()), 64'd7);

    start(16'h1840, 1'b0, 99); drain();
    check("ld E4 rf load", {act_log[9].rf_fun, act_log[9].rf_r, act_log[9].cs}, {2'b01, 4'b0010, 1'b0});

    start(16'h202F, 1'b0, 99); drain();
    check("st E3 word", {act_log[8].cs, act_log[8].wr, act_log[8].outb, act_log[8].o2, act_log[8].alu},
          {1'b0, 1'b1, 2'b00, 3'b100, 4'b0001});
    cnt = 0;
    foreach (act_log[i]) if (act_log[i].wr) cnt++;
    check("st single write", 64'(cnt), 64'd1);

    start(16'h3C00, 1'b0, 99); drain();
    check("inc R4 E0", {act_log[5].rf_fun, act_log[5].rf_r}, {2'b11, 4'b0001});
    start(16'h4000, 1'b1, 99); drain();
    check("dec R1 E0", {act_log[5].rf_fun, act_log[5].rf_r}, {2'b10, 4'b1000});

    start(16'h5010, 1'b1, 99); drain();
    check("bra E1", {act_log[6].arf_r, act_log[6].arf_fun, act_log[6].mb}, {4'b1000, 2'b01, 2'b10});
    start(16'h6010, 1'b0, 99); drain();
    check("bne taken E1", {act_log[6].arf_r, act_log[6].arf_fun, act_log[6].mb}, {4'b1000, 2'b01, 2'b10});
    start(16'h6010, 1'b1, 99); drain();
    cnt = 0;
    foreach (act_log[i]) if (act_log[i].arf_fun == 2'b01) cnt++;
    check("bne not taken no load", 64'(cnt), 64'd0);
    check("bne not taken length", 64'(act_log.size()), 64'd5);

    start(16'h9000, 1'b0, 99);
    start(16'hF0FF, 1'b0, 99);

    // Reset lands during LD E2: E3/E4 must never appear.
    start(16'h1455, 1'b0, 7);
    pulse_reset(idle(2));
    drain();
    cnt = 0;
    foreach (act_log[i]) if (!act_log[i].cs) cnt++;
    check("ld abort mem access", 64'(cnt), 64'd2);
    check("ld abort rst word", {act_log[8].rf_r, act_log[8].rf_fun, act_log[8].sc}, {4'hF, 2'b00, 3'd0});

    start(16'h0CFF, 1'b0, 99);

    start(16'h7000, 1'b0, 99); drain();
    cnt = 0;
    foreach (act_log[i]) if (act_log[i].halted) cnt++;
    check("hlt held cycles", 64'(cnt), 64'd20);
    pulse_reset(halt_word());
    drain();
    check("hlt reset word", {act_log[26].halted, act_log[26].rf_r, act_log[26].ir_en}, {1'b0, 4'hF, 1'b1});

`ifdef CU_STEP_EN
    drain();
    #1;
    step = 1'b0;
    act_log.delete();
    repeat (10) exp_q.push_back(fetch_word(0));
    repeat (10) @(posedge clk);
    #1;
    ir = 16'h042A;
    alu_flags = 4'h0;
    step = 1'b1;
    push_instr(16'h042A, 1'b0, 99);
    @(posedge clk);
    #1;
    step = 1'b0;
    drain();
    #1;
    repeat (5) exp_q.push_back(fetch_word(0));
    drain();
    check("step run length", 64'(act_log.size()), 64'd22);
    step = 1'b1;
`endif

    start(16'h0800, 1'b0, 99);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
